// File: rtl/serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// serial_tx_arbiter
//
// Shares one serial output port between NUM_REQ byte requesters. Requesters are
// granted round-robin. Once a requester is granted a byte that is not LINE_END,
// it keeps the line until it sends LINE_END, so printed lines never interleave.
// Accepted bytes go through a small FIFO. The FIFO drains one byte per cycle
// while serial_ready_in is high.
//
// Optional feature (compile-time macro SERIAL_ARB_TIMEOUT_EN):
//   The lock is force-released after the owner has been idle (req_valid low)
//   for LOCK_TIMEOUT consecutive cycles. No byte is inserted when this happens.
//   Without the macro, the lock is held until LINE_END or reset.
//
// Ports:
//   clock            system clock
//   reset            synchronous, active-high reset
//   req_data         byte from requester i at bits [8i+7:8i]
//   req_valid        requester i has a byte
//   req_ready        byte from requester i is accepted this cycle when valid&ready
//   serial_ready_in  serial sink can take a byte this cycle
//   serial_out       byte to the serial port (holds its last value between strobes)
//   serial_wren_out  one-cycle write strobe for serial_out
//   grant_id         current or last owner index
//   locked           an owner holds the line lock
//   fifo_count       current FIFO occupancy
// -----------------------------------------------------------------------------
module serial_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 3,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [7:0]  LINE_END     = 8'h0A,
   parameter int unsigned LOCK_TIMEOUT = 1024
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [8*NUM_REQ-1:0]          req_data,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          serial_ready_in,
   output logic [7:0]                    serial_out,
   output logic                          serial_wren_out,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          locked,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int IDW  = $clog2(NUM_REQ);
   localparam int PTRW = $clog2(FIFO_DEPTH);
   localparam int CNTW = PTRW + 1;

   // Elaboration-time parameter sanity checks.
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("serial_tx_arbiter: NUM_REQ must be in 2..8");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("serial_tx_arbiter: FIFO_DEPTH must be a power of 2, >= 2");
   end
   if (LOCK_TIMEOUT < 2) begin : g_bad_timeout
      $error("serial_tx_arbiter: LOCK_TIMEOUT must be >= 2");
   end

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t            state, state_nx;
   logic [IDW-1:0]    rr_ptr, rr_nx;
   logic [IDW-1:0]    grant_nx;
   logic [IDW-1:0]    winner;
   logic              found;

   logic              push, pop;
   logic [7:0]        push_data;
   logic              full, empty;
   logic [PTRW-1:0]   wr_ptr, rd_ptr;
   logic [7:0]        mem [FIFO_DEPTH];
   logic [7:0]        req_bytes [NUM_REQ];
   logic              timeout_hit;

   // Unpack the flat request bus into one byte per requester.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_bytes[g] = req_data[8*g +: 8];
   end

   function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
      return (i == IDW'(NUM_REQ - 1)) ? '0 : i + IDW'(1);
   endfunction

   // Full/empty come from the registered count, so a byte popped this cycle
   // does not free a slot for a push in the same cycle.
   assign full   = (fifo_count == CNTW'(FIFO_DEPTH));
   assign empty  = (fifo_count == '0);
   assign pop    = !empty && serial_ready_in;
   assign locked = (state == ST_LOCKED);

   // ---------------------------------------------------------------------------
   // Lock timeout
   // ---------------------------------------------------------------------------
`ifdef SERIAL_ARB_TIMEOUT_EN
   localparam int TW = $clog2(LOCK_TIMEOUT);

   logic [TW-1:0] idle_cnt;

   // The release fires on the idle cycle that would bring the count to
   // LOCK_TIMEOUT, so the line is free after exactly LOCK_TIMEOUT idle cycles.
   assign timeout_hit = (state == ST_LOCKED) && !req_valid[grant_id] &&
                        (idle_cnt == TW'(LOCK_TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset || state != ST_LOCKED || push || timeout_hit) begin
         idle_cnt <= '0;
      end else if (!req_valid[grant_id]) begin
         idle_cnt <= idle_cnt + TW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Arbitration FSM: next state, grant and handshake
   // ---------------------------------------------------------------------------
   always_comb begin : arb_comb
      int idx;
      // NOTE: every output of this block gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_nx  = state;
      grant_nx  = grant_id;
      rr_nx     = rr_ptr;
      req_ready = '0;
      push      = 1'b0;
      push_data = '0;
      found     = 1'b0;
      winner    = rr_ptr;
      idx       = 0;

      // First valid requester at or after rr_ptr, wrapping around.
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end

      case (state)
         ST_IDLE: begin
            if (found && !full) begin
               req_ready[winner] = 1'b1;
               push              = 1'b1;
               push_data         = req_bytes[winner];
               grant_nx          = winner;
               if (push_data == LINE_END) begin
                  // A lone LINE_END does not lock; the next requester gets a turn.
                  rr_nx = next_idx(winner);
               end else begin
                  state_nx = ST_LOCKED;
               end
            end
         end
         ST_LOCKED: begin
            // Only the owner may send; everyone else stalls regardless of valid.
            if (!full) req_ready[grant_id] = 1'b1;
            if (!full && req_valid[grant_id]) begin
               push      = 1'b1;
               push_data = req_bytes[grant_id];
               if (push_data == LINE_END) begin
                  state_nx = ST_IDLE;
                  rr_nx    = next_idx(grant_id);
               end
            end else if (timeout_hit) begin
               state_nx = ST_IDLE;
               rr_nx    = next_idx(grant_id);
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples its inputs from before the edge, independent of statement order.
      if (reset) begin
         state    <= ST_IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_nx;
         grant_id <= grant_nx;
         rr_ptr   <= rr_nx;
      end
   end

   // ---------------------------------------------------------------------------
   // Output FIFO and serial strobe
   // ---------------------------------------------------------------------------
   // NOTE: the storage array has no reset; the pointers and count define which
   // entries are valid, so stale data is never read.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_count      <= '0;
         serial_out      <= '0;
         serial_wren_out <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTRW'(1);
         if (pop) begin
            rd_ptr     <= rd_ptr + PTRW'(1);
            serial_out <= mem[rd_ptr];
         end
         serial_wren_out <= pop;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNTW'(1);
            2'b01:   fifo_count <= fifo_count - CNTW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_arbiter
//
// Directed self-checking bench for serial_tx_arbiter with NUM_REQ=3,
// FIFO_DEPTH=8, LINE_END=0x0A and LOCK_TIMEOUT=16. Inputs are driven and
// outputs are sampled on the falling clock edge. A monitor records every
// serial strobe into a queue so byte order can be compared against the
// expected sequence.
// -----------------------------------------------------------------------------
module tb_serial_tx_arbiter;

   localparam int NUM_REQ    = 3;
   localparam int FIFO_DEPTH = 8;

   logic                 clock;
   logic                 reset;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 serial_ready_in;
   logic [7:0]           serial_out;
   logic                 serial_wren_out;
   logic [1:0]           grant_id;
   logic                 locked;
   logic [3:0]           fifo_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] out_q [$];

   serial_tx_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .LINE_END     (8'h0A),
      .LOCK_TIMEOUT (16)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .req_data        (req_data),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .serial_ready_in (serial_ready_in),
      .serial_out      (serial_out),
      .serial_wren_out (serial_wren_out),
      .grant_id        (grant_id),
      .locked          (locked),
      .fifo_count      (fifo_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Strobe monitor: samples shortly after the rising edge.
   always @(posedge clock) begin
      #2;
      if (serial_wren_out === 1'b1) out_q.push_back(serial_out);
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] q_at(input int i);
      if (i < out_q.size()) return out_q[i];
      return 8'hxx;
   endfunction

   // Called at a falling edge: one cycle of reset, then release.
   task automatic do_reset();
      req_valid = '0;
      reset     = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      out_q.delete();
   endtask

   // Present byte b on requester r, wait (bounded) for ready, let the
   // handshake edge pass, then drop valid. Returns at a falling edge.
   task automatic send(input int r, input logic [7:0] b, input string tag);
      int waited;
      waited = 0;
      req_data[r*8 +: 8] = b;
      req_valid[r]       = 1'b1;
      #1;
      while (req_ready[r] !== 1'b1 && waited < 50) begin
         @(negedge clock);
         #1;
         waited++;
      end
      check({tag, " ready"}, {31'd0, req_ready[r]}, 32'd1);
      @(negedge clock);
      req_valid[r] = 1'b0;
   endtask

   initial begin
      int lk;
      int stall_seen;

      reset           = 1'b1;
      req_data        = '0;
      req_valid       = '0;
      serial_ready_in = 1'b1;
      repeat (2) @(negedge clock);

      // ---------------- reset state ----------------
      check("rst serial_out", serial_out, 8'h00);
      check("rst wren",       serial_wren_out, 1'b0);
      check("rst grant_id",   grant_id, 2'd0);
      check("rst locked",     locked, 1'b0);
      check("rst fifo_count", fifo_count, 4'd0);
      reset = 1'b0;
      out_q.delete();

      // ---------------- test 1: "Hi\n" from req0 ----------------
      req_data[7:0] = 8'h48;
      req_valid     = 3'b001;
      #1;
      check("t1 ready first", req_ready, 3'b001);
      @(negedge clock);
      check("t1 locked after H", locked, 1'b1);
      check("t1 count after H",  fifo_count, 4'd1);
      check("t1 no strobe yet",  serial_wren_out, 1'b0);
      req_data[7:0] = 8'h69;
      @(negedge clock);
      check("t1 strobe1",        serial_wren_out, 1'b1);
      check("t1 byte1",          serial_out, 8'h48);
      check("t1 locked after i", locked, 1'b1);
      check("t1 count push+pop", fifo_count, 4'd1);
      req_data[7:0] = 8'h0A;
      @(negedge clock);
      check("t1 unlocked after LF", locked, 1'b0);
      check("t1 strobe2",           serial_wren_out, 1'b1);
      check("t1 byte2",             serial_out, 8'h69);
      req_valid = '0;
      @(negedge clock);
      check("t1 strobe3",   serial_wren_out, 1'b1);
      check("t1 byte3",     serial_out, 8'h0A);
      check("t1 drained",   fifo_count, 4'd0);
      @(negedge clock);
      check("t1 strobe off", serial_wren_out, 1'b0);
      check("t1 out holds",  serial_out, 8'h0A);

      // ---------------- test 2: req0 "A\n" vs req1 "B\n" ----------------
      do_reset();
      req_data[7:0]  = 8'h41;
      req_data[15:8] = 8'h42;
      req_valid      = 3'b011;
      #1;
      check("t2 req0 wins", req_ready, 3'b001);
      @(negedge clock);
      req_data[7:0] = 8'h0A;
      #1;
      check("t2 req1 stalled", req_ready, 3'b001);
      check("t2 owner 0",      grant_id, 2'd0);
      @(negedge clock);
      req_valid = 3'b010;
      #1;
      check("t2 req1 granted", req_ready, 3'b010);
      @(negedge clock);
      check("t2 owner 1", grant_id, 2'd1);
      check("t2 locked 1", locked, 1'b1);
      req_data[15:8] = 8'h0A;
      @(negedge clock);
      req_valid = '0;
      repeat (4) @(negedge clock);
      check("t2 out count", out_q.size(), 32'd4);
      check("t2 out0", q_at(0), 8'h41);
      check("t2 out1", q_at(1), 8'h0A);
      check("t2 out2", q_at(2), 8'h42);
      check("t2 out3", q_at(3), 8'h0A);

      // ---------------- test 3: round-robin rotation ----------------
      do_reset();
      req_data  = {8'h0A, 8'h0A, 8'h0A};
      req_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("t3 ready %0d", i), req_ready, 3'b001 << (i % 3));
         @(negedge clock);
         check($sformatf("t3 grant %0d", i), grant_id, i % 3);
      end
      check("t3 never locked", locked, 1'b0);
      req_valid = '0;
      repeat (3) @(negedge clock);

      // ---------------- test 4: backpressure fills FIFO ----------------
      do_reset();
      serial_ready_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send(0, 8'h30 + 8'(i), $sformatf("t4 push %0d", i));
      end
      req_data[7:0] = 8'h38;
      req_valid[0]  = 1'b1;
      #1;
      check("t4 full count",   fifo_count, 4'd8);
      check("t4 full stalls",  req_ready, 3'b000);
      check("t4 lock kept",    locked, 1'b1);
      repeat (3) @(negedge clock);
      #1;
      check("t4 still full",   fifo_count, 4'd8);
      check("t4 still stall",  req_ready, 3'b000);
      check("t4 no strobes",   out_q.size(), 32'd0);
      serial_ready_in = 1'b1;
      send(0, 8'h38, "t4 push 8");
      send(0, 8'h39, "t4 push 9");
      repeat (15) @(negedge clock);
      check("t4 out count", out_q.size(), 32'd10);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("t4 out%0d", i), q_at(i), 8'h30 + 8'(i));
      end
      check("t4 lock after drain", locked, 1'b1);

      // ---------------- test 5: reset mid-line ----------------
      do_reset();
      serial_ready_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(2, 8'h50 + 8'(i), $sformatf("t5 push %0d", i));
      end
      check("t5 pre owner",  grant_id, 2'd2);
      check("t5 pre locked", locked, 1'b1);
      check("t5 pre count",  fifo_count, 4'd5);
      reset           = 1'b1;
      serial_ready_in = 1'b1;
      @(negedge clock);
      check("t5 locked",   locked, 1'b0);
      check("t5 count",    fifo_count, 4'd0);
      check("t5 wren",     serial_wren_out, 1'b0);
      check("t5 grant_id", grant_id, 2'd0);
      reset = 1'b0;
      out_q.delete();
      repeat (3) @(negedge clock);
      check("t5 no stale bytes", out_q.size(), 32'd0);

      // ---------------- test 6: lock timeout ----------------
      do_reset();
      req_data[15:8] = 8'h42;
      req_valid[1]   = 1'b1;
      send(0, 8'h41, "t6 owner byte");
      check("t6 owner 0", grant_id, 2'd0);
`ifdef SERIAL_ARB_TIMEOUT_EN
      lk = 0;
      while (locked === 1'b1 && lk < 40) begin
         lk++;
         @(negedge clock);
      end
      check("t6 locked cycles", lk, 32'd16);
      send(1, 8'h42, "t6 req1 after release");
      check("t6 new owner", grant_id, 2'd1);
      req_valid = '0;
      repeat (4) @(negedge clock);
      check("t6 out count", out_q.size(), 32'd2);
      check("t6 out1", q_at(1), 8'h42);
`else
      stall_seen = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (req_ready[1] === 1'b1) stall_seen++;
         @(negedge clock);
      end
      check("t6 req1 stalled", stall_seen, 32'd0);
      check("t6 lock held",    locked, 1'b1);
      check("t6 owner kept",   grant_id, 2'd0);
      req_valid = '0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
